// File: rtl/fc_weight_loader.sv
// fc_weight_loader: assembles a DIM_OUT x DIM_IN weight matrix from LANES-wide
// valid/ready beats (row-major) and commits it to the downstream weight register
// with a one-cycle w_load pulse.
// Optional feature macro: WLOAD_LAST_CHK_EN (s_last framing check, sticky err).
module fc_weight_loader #(
    parameter int DIM_OUT = 3,
    parameter int DIM_IN  = 110,
    parameter int INWD    = 16,
    parameter int LANES   = 10
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [LANES*INWD-1:0]                   s_data,
    input  logic                                    s_last,
    output logic [DIM_OUT-1:0][DIM_IN-1:0][INWD-1:0] w_out,
    output logic                                    w_load,
    output logic [7:0]                              frame_cnt,
    output logic                                    err
);

    localparam int COLS = DIM_IN / LANES;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (DIM_OUT > 1) ? $clog2(DIM_OUT) : 1;
    localparam int XW   = (DIM_IN > 1) ? $clog2(DIM_IN) : 1;

    // A beat must map onto whole lanes of a row; refuse to elaborate otherwise.
    generate
        if (DIM_IN % LANES != 0) begin : g_bad_lanes
            $error("fc_weight_loader: DIM_IN must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t                                  state_q, state_d;
    logic [RW-1:0]                           row_q, row_d;
    logic [CW-1:0]                           col_q, col_d;
    logic                                    s_ready_q, s_ready_d;
    logic                                    w_load_q, w_load_d;
    logic [7:0]                              frame_cnt_q, frame_cnt_d;
    logic [DIM_OUT-1:0][DIM_IN-1:0][INWD-1:0] w_q, w_d;
    logic                                    err_q, err_d;

    logic                                    accept_s;
    logic                                    final_s;
    logic                                    col_wrap_s;
    logic [XW-1:0]                           col_base_s;

    // Beat handshake and position decode of the current write slot.
    always_comb begin
        accept_s   = s_valid & s_ready_q;
        col_wrap_s = (col_q == CW'(COLS - 1));
        final_s    = (row_q == RW'(DIM_OUT - 1)) && col_wrap_s;
        col_base_s = XW'(int'(col_q) * LANES);
    end

    // Next-state, counter, staging and status logic.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        w_d         = w_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        case (state_q)
            ST_FILL: begin
                if (flush) begin
                    // Abort the partial matrix; a beat in this cycle is dropped.
                    row_d = RW'(0);
                    col_d = CW'(0);
                end else if (accept_s) begin
                    w_d[row_q][col_base_s +: LANES] = s_data;
                    if (final_s) begin
                        row_d   = RW'(0);
                        col_d   = CW'(0);
                        state_d = ST_COMMIT;
`ifdef WLOAD_LAST_CHK_EN
                        // Missing s_last is flagged but the matrix still commits.
                        if (!s_last) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
`endif
                    end
`ifdef WLOAD_LAST_CHK_EN
                    else if (s_last) begin
                        // Early s_last: discard this matrix and restart framing.
                        err_d = 1'b1;
                        row_d = RW'(0);
                        col_d = CW'(0);
                    end
`endif
                    else if (col_wrap_s) begin
                        col_d = CW'(0);
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_COMMIT: begin
                // Single commit cycle; flush here has nothing left to abort.
                frame_cnt_d = frame_cnt_q + 8'd1;
                state_d     = ST_FILL;
            end
            default: begin
                state_d = ST_FILL;
                row_d   = RW'(0);
                col_d   = CW'(0);
            end
        endcase
        s_ready_d = (state_d == ST_FILL);
        w_load_d  = (state_d == ST_COMMIT);
    end

    // State, counters, staging matrix and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            row_q       <= RW'(0);
            col_q       <= CW'(0);
            s_ready_q   <= 1'b0;
            w_load_q    <= 1'b0;
            frame_cnt_q <= 8'd0;
            w_q         <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            s_ready_q   <= s_ready_d;
            w_load_q    <= w_load_d;
            frame_cnt_q <= frame_cnt_d;
            w_q         <= w_d;
            err_q       <= err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign w_load    = w_load_q;
    assign frame_cnt = frame_cnt_q;
    assign w_out     = w_q;

`ifdef WLOAD_LAST_CHK_EN
    assign err = err_q;
`else
    // Without the framing check s_last carries no meaning here.
    logic unused_last_s;
    logic unused_err_s;
    assign unused_last_s = s_last;
    assign unused_err_s  = err_q;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_fc_weight_loader.sv
// Self-checking bench for fc_weight_loader against a flat-array matrix model.
module tb_fc_weight_loader;

    localparam int DIM_OUT = 3;
    localparam int DIM_IN  = 110;
    localparam int INWD    = 16;
    localparam int LANES   = 10;
    localparam int DW      = LANES * INWD;
    localparam int TOTAL   = DIM_OUT * DIM_IN;
    localparam int BEATS   = TOTAL / LANES;
`ifdef WLOAD_LAST_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, flush, s_valid, s_ready, s_last, w_load, err;
    logic [DW-1:0] s_data;
    logic [DIM_OUT-1:0][DIM_IN-1:0][INWD-1:0] w_out;
    logic [7:0] frame_cnt;

    fc_weight_loader #(.DIM_OUT(DIM_OUT), .DIM_IN(DIM_IN), .INWD(INWD), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .w_out(w_out), .w_load(w_load),
        .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wl_cnt = 0;
    int wl_cyc = -1;
    int rdy_low = 0;
    int last_acc = 0;
    int beats_sent = 0;

    // Reference model: flat row-major word array plus word position.
    logic [INWD-1:0] model_w [TOTAL];
    int   pos;
    int   exp_frames;
    logic exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe commit pulses and ready-low cycles away from the active edge.
    always @(negedge clk) begin
        if (w_load === 1'b1) begin
            wl_cnt <= wl_cnt + 1;
            wl_cyc <= cyc;
        end
        if (rst === 1'b0 && s_ready === 1'b0) rdy_low <= rdy_low + 1;
    end

    task automatic model_reset();
        for (int i = 0; i < TOTAL; i++) model_w[i] = '0;
        pos = 0;
        exp_frames = 0;
        exp_err = 1'b0;
    endtask

    function automatic int mismatches();
        int n = 0;
        for (int i = 0; i < TOTAL; i++)
            if (w_out[i / DIM_IN][i % DIM_IN] !== model_w[i]) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] ramp(int b);
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*INWD +: INWD] = INWD'(b * LANES + k);
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*INWD +: INWD] = INWD'($urandom);
        return r;
    endfunction

    // Presents one beat (called at a negedge), waits for acceptance, updates the model.
    task automatic send_beat(input logic [DW-1:0] d, input logic last, input bit gap);
        int guard;
        bit fin;
        guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (s_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL ready_timeout s_ready=%b required=1", s_ready);
        end
        @(negedge clk);
        last_acc = cyc;
        s_valid = 1'b0;
        s_last  = 1'b0;
        beats_sent++;
        fin = (pos + LANES == TOTAL);
        for (int k = 0; k < LANES; k++) model_w[pos + k] = d[k*INWD +: INWD];
        if (CHK_EN && !fin && last) begin
            exp_err = 1'b1;
            pos = 0;
        end else if (fin) begin
            if (CHK_EN && !last) exp_err = 1'b1;
            pos = 0;
            exp_frames++;
        end else begin
            pos += LANES;
        end
        if (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", s_ready); end
        checks++;
        if (w_load !== 1'b0) begin errors++; $display("FAIL rst_wload got=%b exp=0", w_load); end
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame got=%0d exp=0", frame_cnt); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++;
        if (mismatches() !== 0) begin errors++; $display("FAIL rst_wout bad_words=%0d exp=0", mismatches()); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_stream(input bit toggle, input string nm);
        int wl0, r0, f;
        wl0 = wl_cnt; r0 = rdy_low;
        for (int b = 0; b < BEATS; b++) send_beat(ramp(b), (b == BEATS - 1), toggle);
        repeat (3) @(negedge clk);
        checks++;
        if (wl_cnt - wl0 !== 1) begin errors++; $display("FAIL %s_wload_count got=%0d exp=1", nm, wl_cnt - wl0); end
        checks++;
        if (wl_cyc !== last_acc) begin errors++; $display("FAIL %s_wload_cycle got=%0d exp=%0d", nm, wl_cyc, last_acc); end
        checks++;
        if (rdy_low - r0 !== 1) begin errors++; $display("FAIL %s_ready_low got=%0d exp=1", nm, rdy_low - r0); end
        f = exp_frames;
        checks++;
        if (frame_cnt !== 8'(f)) begin errors++; $display("FAIL %s_frame got=%0d exp=%0d", nm, frame_cnt, f); end
        checks++;
        if (w_out[2][109] !== 16'd329) begin errors++; $display("FAIL %s_w2_109 got=%0d exp=329", nm, w_out[2][109]); end
        checks++;
        if (w_out[0][0] !== 16'd0) begin errors++; $display("FAIL %s_w0_0 got=%0d exp=0", nm, w_out[0][0]); end
        checks++;
        if (mismatches() !== 0) begin errors++; $display("FAIL %s_wout bad_words=%0d exp=0", nm, mismatches()); end
    endtask

    task automatic test_flush();
        int wl0;
        logic [DW-1:0] aa;
        do_reset();
        wl0 = wl_cnt;
        for (int b = 0; b < 15; b++) send_beat(rnd_beat(), 1'b0, 1'b0);
        // Flush with a simultaneous beat: that beat must be dropped.
        flush = 1'b1; s_valid = 1'b1; s_data = {LANES{16'h5555}};
        @(negedge clk);
        flush = 1'b0; s_valid = 1'b0;
        pos = 0;
        checks++;
        if (wl_cnt - wl0 !== 0) begin errors++; $display("FAIL flush_no_wload got=%0d exp=0", wl_cnt - wl0); end
        aa = {LANES{16'hAAAA}};
        for (int b = 0; b < BEATS - 1; b++) send_beat(aa, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (wl_cnt - wl0 !== 0) begin errors++; $display("FAIL flush_early_commit got=%0d exp=0", wl_cnt - wl0); end
        send_beat(aa, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (wl_cnt - wl0 !== 1) begin errors++; $display("FAIL flush_wload got=%0d exp=1", wl_cnt - wl0); end
        checks++;
        if (mismatches() !== 0) begin errors++; $display("FAIL flush_wout bad_words=%0d exp=0", mismatches()); end
        checks++;
        if (w_out[1][55] !== 16'hAAAA) begin errors++; $display("FAIL flush_w1_55 got=%h exp=aaaa", w_out[1][55]); end
        checks++;
        if (frame_cnt !== 8'd1) begin errors++; $display("FAIL flush_frame got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_reset_mid();
        int wl0;
        wl0 = wl_cnt;
        for (int b = 0; b < 20; b++) send_beat(rnd_beat(), 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (s_ready !== 1'b0 || w_load !== 1'b0 || frame_cnt !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs ready=%b wload=%b frame=%0d err=%b exp=0/0/0/0", s_ready, w_load, frame_cnt, err);
        end
        checks++;
        if (mismatches() !== 0) begin errors++; $display("FAIL midrst_wout bad_words=%0d exp=0", mismatches()); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wl_cnt - wl0 !== 0) begin errors++; $display("FAIL midrst_no_wload got=%0d exp=0", wl_cnt - wl0); end
        for (int b = 0; b < BEATS; b++) send_beat(rnd_beat(), (b == BEATS - 1), 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (wl_cnt - wl0 !== 1) begin errors++; $display("FAIL midrst_wload got=%0d exp=1", wl_cnt - wl0); end
        checks++;
        if (frame_cnt !== 8'd1) begin errors++; $display("FAIL midrst_frame got=%0d exp=1", frame_cnt); end
        checks++;
        if (mismatches() !== 0) begin errors++; $display("FAIL midrst_wout bad_words=%0d exp=0", mismatches()); end
    endtask

    task automatic test_last_chk();
        int wl0, f0, n, b0;
        logic lst;
        wl0 = wl_cnt; f0 = exp_frames; n = 0; b0 = beats_sent;
        while (exp_frames == f0 && n < 100) begin
            lst = (n == 9) ? 1'b1 : (pos + LANES == TOTAL);
            send_beat(rnd_beat(), lst, 1'b0);
            if (n == 9) begin
                checks++;
                if (err !== exp_err) begin errors++; $display("FAIL last_err_early got=%b exp=%b", err, exp_err); end
            end
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (beats_sent - b0 !== (CHK_EN ? 43 : 33)) begin
            errors++;
            $display("FAIL last_beats got=%0d exp=%0d", beats_sent - b0, CHK_EN ? 43 : 33);
        end
        checks++;
        if (wl_cnt - wl0 !== 1) begin errors++; $display("FAIL last_wload got=%0d exp=1", wl_cnt - wl0); end
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL last_err_sticky got=%b exp=%b", err, exp_err); end
        checks++;
        if (mismatches() !== 0) begin errors++; $display("FAIL last_wout bad_words=%0d exp=0", mismatches()); end
    endtask

    task automatic test_wrap();
        int wl0;
        do_reset();
        wl0 = wl_cnt;
        for (int m = 0; m < 256; m++) begin
            for (int b = 0; b < BEATS; b++)
                send_beat(rnd_beat(), (b == BEATS - 1), ($urandom_range(0, 3) == 0));
            if (m == 254) begin
                repeat (2) @(negedge clk);
                checks++;
                if (frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d exp=255", frame_cnt); end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", frame_cnt); end
        checks++;
        if (wl_cnt - wl0 !== 256) begin errors++; $display("FAIL wrap_wloads got=%0d exp=256", wl_cnt - wl0); end
        checks++;
        if (mismatches() !== 0) begin errors++; $display("FAIL wrap_wout bad_words=%0d exp=0", mismatches()); end
    endtask

    initial begin
        test_reset();
        test_stream(1'b0, "b2b");
        test_stream(1'b1, "toggle");
        test_flush();
        test_reset_mid();
        test_last_chk();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
